// File: rtl/ram_sram_param.sv
// Single-port byte-enabled SRAM with a zeroing sweep after reset or on request
// and an optional output register stage on the read path.
module ram_sram_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int OUT_REG = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   r_w,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      datain,
  input  logic [DATA_W/8-1:0]    be,
  input  logic                   clear,
  output logic [DATA_W-1:0]      dataout,
  output logic                   rd_valid,
  output logic                   busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                accept;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata, mem_rword;
  logic [DATA_W-1:0]   rdata1_d, rdata1_q;
  logic                rvalid1_d, rvalid1_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    accept  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear) begin
          ptr_d   = '0;
          state_d = ST_CLEAR;
        end else begin
          accept = enable;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy      = (state_q == ST_CLEAR);
  assign mem_rword = mem[address];

  // Partial writes merge into the current word so the array keeps one full-word write port.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = mem_rword;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = '0;
    end else if (accept && r_w) begin
      mem_we = 1'b1;
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem_wdata[8*i +: 8] = datain[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rvalid1_d = accept && !r_w;
    rdata1_d  = rvalid1_d ? mem_rword : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1_q  <= '0;
      rvalid1_q <= 1'b0;
    end else begin
      rdata1_q  <= rdata1_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // The second stage copies unconditionally so a read in flight survives a clear.
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] rdata2_q;
    logic              rvalid2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata2_q  <= '0;
        rvalid2_q <= 1'b0;
      end else begin
        rdata2_q  <= rdata1_q;
        rvalid2_q <= rvalid1_q;
      end
    end

    assign dataout  = rdata2_q;
    assign rd_valid = rvalid2_q;
  end else begin : g_no_out_reg
    assign dataout  = rdata1_q;
    assign rd_valid = rvalid1_q;
  end

endmodule

// File: tb/tb_ram_sram_param.sv
// Directed bench: an 8-bit 1-cycle instance and a 32-bit 2-cycle instance
// run in lockstep from shared stimulus.
module tb_ram_sram_param;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        r_w;
  logic [4:0]  address;
  logic [31:0] datain;
  logic [3:0]  be;
  logic        clear;
  logic [7:0]  dout_a;
  logic        valid_a, busy_a;
  logic [31:0] dout_b;
  logic        valid_b, busy_b;

  int checks = 0;
  int errors = 0;
  int cnt;

  ram_sram_param #(.DATA_W(8), .ADDR_W(5), .OUT_REG(0)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .r_w(r_w), .address(address),
    .datain(datain[7:0]), .be(be[0]), .clear(clear),
    .dataout(dout_a), .rd_valid(valid_a), .busy(busy_a)
  );

  ram_sram_param #(.DATA_W(32), .ADDR_W(5), .OUT_REG(1)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .r_w(r_w), .address(address),
    .datain(datain), .be(be), .clear(clear),
    .dataout(dout_b), .rd_valid(valid_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    enable = 1'b1; r_w = 1'b1; address = a; datain = d; be = b;
    step();
    enable = 1'b0;
    chk("wr_no_valid_a", 64'(valid_a), 64'd0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp_a, input logic [31:0] exp_b);
    enable = 1'b1; r_w = 1'b0; address = a;
    step();
    enable = 1'b0;
    chk("rd_data_a", 64'(dout_a), 64'(exp_a));
    chk("rd_valid_a", 64'(valid_a), 64'd1);
    chk("rd_early_valid_b", 64'(valid_b), 64'd0);
    chk("rd_early_data_b", 64'(dout_b), 64'd0);
    step();
    chk("rd_after_valid_a", 64'(valid_a), 64'd0);
    chk("rd_after_data_a", 64'(dout_a), 64'd0);
    chk("rd_data_b", 64'(dout_b), 64'(exp_b));
    chk("rd_valid_b", 64'(valid_b), 64'd1);
    step();
    chk("rd_after_valid_b", 64'(valid_b), 64'd0);
    chk("rd_after_data_b", 64'(dout_b), 64'd0);
  endtask

  task automatic wait_sweep(input string tag);
    cnt = 0;
    while (busy_a && cnt < 100) begin
      step();
      cnt++;
    end
    chk(tag, 64'(cnt), 64'd32);
    chk("busy_b_match", 64'(busy_b), 64'd0);
  endtask

  task automatic rd_all_zero();
    for (int i = 0; i < 32; i++) begin
      enable = 1'b1; r_w = 1'b0; address = 5'(i);
      step();
      chk("zero_data_a", 64'(dout_a), 64'd0);
      chk("zero_valid_a", 64'(valid_a), 64'd1);
      chk("zero_data_b", 64'(dout_b), 64'd0);
      chk("zero_valid_b", 64'(valid_b), (i > 0) ? 64'd1 : 64'd0);
    end
    enable = 1'b0;
    step();
    chk("zero_tail_valid_a", 64'(valid_a), 64'd0);
    chk("zero_tail_valid_b", 64'(valid_b), 64'd1);
    step();
    chk("zero_end_valid_b", 64'(valid_b), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; r_w = 1'b0; address = '0;
    datain = '0; be = '0; clear = 1'b0;
    #2;
    chk("rst_busy_a", 64'(busy_a), 64'd1);
    chk("rst_busy_b", 64'(busy_b), 64'd1);
    chk("rst_valid_a", 64'(valid_a), 64'd0);
    chk("rst_data_b", 64'(dout_b), 64'd0);
    step();
    step();
    rst_n = 1'b1;

    wait_sweep("init_sweep_len");
    rd_all_zero();

    wr(5'd3, 32'h0000_00A5, 4'b0001);
    rd(5'd3, 8'hA5, 32'h0000_00A5);
    wr(5'd3, 32'h5A5A_5A5A, 4'b0000);
    rd(5'd3, 8'hA5, 32'h0000_00A5);

    wr(5'd0, 32'h1122_3344, 4'b1111);
    wr(5'd0, 32'hFFFF_FFFF, 4'b0101);
    rd(5'd0, 8'hFF, 32'h11FF_33FF);

    for (int i = 0; i < 8; i++) wr(5'(i), 32'(i + 1), 4'b1111);
    for (int i = 0; i < 8; i++) begin
      enable = 1'b1; r_w = 1'b0; address = 5'(i);
      step();
      chk("b2b_data_a", 64'(dout_a), 64'(i + 1));
      chk("b2b_valid_a", 64'(valid_a), 64'd1);
      if (i > 0) begin
        chk("b2b_data_b", 64'(dout_b), 64'(i));
        chk("b2b_valid_b", 64'(valid_b), 64'd1);
      end
    end
    enable = 1'b0;
    step();
    chk("b2b_last_data_b", 64'(dout_b), 64'd8);
    chk("b2b_last_valid_b", 64'(valid_b), 64'd1);
    chk("b2b_idle_valid_a", 64'(valid_a), 64'd0);
    step();
    chk("b2b_end_valid_b", 64'(valid_b), 64'd0);

    wr(5'd5, 32'hCAFE_0077, 4'b1111);
    step();
    enable = 1'b1; r_w = 1'b0; address = 5'd5;
    step();
    chk("pre_clear_data_a", 64'(dout_a), 64'h77);
    address = 5'd3; clear = 1'b1;
    step();
    clear = 1'b0; r_w = 1'b1; datain = 32'hEEEE_EEEE; be = 4'b1111;
    chk("clear_busy_a", 64'(busy_a), 64'd1);
    chk("clear_drop_valid_a", 64'(valid_a), 64'd0);
    chk("clear_drop_data_a", 64'(dout_a), 64'd0);
    chk("inflight_valid_b", 64'(valid_b), 64'd1);
    chk("inflight_data_b", 64'(dout_b), 64'hCAFE_0077);
    cnt = 1;
    while (busy_a && cnt < 100) begin
      clear = (cnt == 10);
      step();
      if (busy_a) cnt++;
      chk("sweep_valid_b", 64'(valid_b), 64'd0);
    end
    enable = 1'b0; clear = 1'b0;
    chk("clear_sweep_len", 64'(cnt), 64'd32);
    rd(5'd3, 8'h00, 32'h0);
    rd(5'd5, 8'h00, 32'h0);

    wr(5'd7, 32'h1357_9BDF, 4'b1111);
    enable = 1'b1; r_w = 1'b0; address = 5'd7;
    step();
    chk("pre_rst_data_a", 64'(dout_a), 64'hDF);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_data_a", 64'(dout_a), 64'd0);
    chk("rst_mid_valid_a", 64'(valid_a), 64'd0);
    chk("rst_mid_valid_b", 64'(valid_b), 64'd0);
    chk("rst_mid_busy_a", 64'(busy_a), 64'd1);
    r_w = 1'b1; datain = 32'hA5A5_A5A5; be = 4'b1111; address = 5'd7;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    chk("rst_sweep_valid_b", 64'(valid_b), 64'd0);
    step();
    rst_n = 1'b1;
    wait_sweep("restart_sweep_len");
    enable = 1'b0;
    rd_all_zero();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
